// File: rtl/bus8085_pkg.sv
// Shared types for the 8085 bus slave: access state encoding, wait counter sizing
// and the 16-bit bus address type.
package bus8085_pkg;

    typedef enum logic [2:0] {IDLE, ADDR, WAIT, ACCESS, DONE} bus_state_t;

    localparam int MAX_WAIT = 7;
    localparam int WCNT_W   = 3;

    typedef logic [15:0] addr_t;

endpackage

// File: rtl/bus_ram.sv
// Single-port byte RAM with a registered read port (one cycle latency).
// The array is deliberately left unreset.
module bus_ram #(
    parameter int ADDR_BITS = 10
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [ADDR_BITS-1:0] addr,
    input  logic [7:0]           wdata,
    output logic [7:0]           rdata
);

    logic [7:0] mem [0:2**ADDR_BITS-1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/bus_slave_mem.sv
// 8085 bus slave: latches the multiplexed low address on ALE, decodes a RAM window
// and one I/O port, and stretches hit accesses with programmable READY wait states.
module bus_slave_mem
    import bus8085_pkg::*;
#(
    parameter int          ADDR_BITS   = 10,
    parameter logic [15:0] MEM_BASE    = 16'h0000,
    parameter logic [7:0]  IO_PORT     = 8'hF0,
    parameter int          WAIT_STATES = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] haddress,
    input  logic [7:0] ad_in,
    output logic [7:0] ad_out,
    output logic       ad_oe,
    input  logic       ale,
    input  logic       iomn,
    input  logic       rdn,
    input  logic       wrn,
    output logic       ready,
    input  logic [7:0] io_port_in,
    output logic [7:0] io_port_out,
    output logic       hit,
    output logic       bus_err
);

    localparam logic [WCNT_W-1:0] WAIT_LOAD = WCNT_W'(WAIT_STATES);

    bus_state_t             state;
    logic [ADDR_BITS-1:0]   ram_addr;
    logic                   iom;
    logic                   is_write;
    logic [WCNT_W-1:0]      wcnt;
    logic [7:0]             wbuf;
    logic [7:0]             ram_rdata;
    logic                   ram_we;
    logic                   rd_low;
    logic                   wr_low;
    logic                   both_low;
    logic                   wrong_type;
    addr_t                  next_addr;
    logic                   next_hit;

    assign rd_low     = ~rdn;
    assign wr_low     = ~wrn;
    assign both_low   = rd_low & wr_low;
    assign wrong_type = is_write ? rd_low : wr_low;

    assign next_addr = {haddress, ad_in};
    assign next_hit  = iomn ? (next_addr[7:0] == IO_PORT)
                            : (next_addr[15:ADDR_BITS] == MEM_BASE[15:ADDR_BITS]);

    // Memory commit happens on the edge where a clean write strobe is released;
    // a simultaneous ALE aborts it.
    assign ram_we = (state == ACCESS) && !ale && is_write && !iom && !rd_low && !wr_low;

    bus_ram #(.ADDR_BITS(ADDR_BITS)) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (wbuf),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            ram_addr    <= '0;
            iom         <= 1'b0;
            hit         <= 1'b0;
            is_write    <= 1'b0;
            wcnt        <= '0;
            wbuf        <= '0;
            ready       <= 1'b1;
            ad_oe       <= 1'b0;
            ad_out      <= '0;
            io_port_out <= '0;
            bus_err     <= 1'b0;
        end else if (ale) begin
            ram_addr <= next_addr[ADDR_BITS-1:0];
            iom      <= iomn;
            hit      <= next_hit;
            ready    <= 1'b1;
            ad_oe    <= 1'b0;
            state    <= ADDR;
        end else begin
            if (wr_low) begin
                wbuf <= ad_in;
            end
            case (state)
                ADDR: begin
                    if (hit && (rd_low || wr_low)) begin
                        if (both_low) begin
                            bus_err <= 1'b1;
                            state   <= DONE;
                        end else begin
                            is_write <= wr_low;
                            wcnt     <= WAIT_LOAD;
                            if (WAIT_STATES == 0) begin
                                state <= ACCESS;
                            end else begin
                                ready <= 1'b0;
                                state <= WAIT;
                            end
                        end
                    end
                end
                WAIT: begin
                    wcnt <= wcnt - WCNT_W'(1);
                    if (both_low || wrong_type) begin
                        bus_err <= 1'b1;
                        ready   <= 1'b1;
                        state   <= DONE;
                    end else if (wcnt == WCNT_W'(1)) begin
                        ready <= 1'b1;
                        state <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (both_low || wrong_type) begin
                        bus_err <= 1'b1;
                        ad_oe   <= 1'b0;
                        state   <= DONE;
                    end else if (is_write) begin
                        if (!wr_low) begin
                            if (iom) begin
                                io_port_out <= wbuf;
                            end
                            state <= DONE;
                        end
                    end else if (rd_low) begin
                        ad_oe  <= 1'b1;
                        ad_out <= iom ? io_port_in : ram_rdata;
                    end else begin
                        ad_oe <= 1'b0;
                        state <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_slave_mem.sv
// Bench for bus_slave_mem: three instances (0, 1 and 3 wait states) share one bus and
// are compared against a byte-array model of RAM, the I/O port and the error flag.
module tb_bus_slave_mem;

    localparam int N = 3;
    localparam int WS [N] = '{0, 1, 3};

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] haddress;
    logic [7:0] ad_in;
    logic [7:0] io_port_in;
    logic       ale;
    logic       iomn;
    logic       rdn;
    logic       wrn;

    logic [7:0] ad_out_a [N];
    logic [7:0] io_out_a [N];
    logic       ad_oe_a  [N];
    logic       ready_a  [N];
    logic       hit_a    [N];
    logic       err_a    [N];

    logic [7:0] mem_m [0:1023];
    bit         mem_v [0:1023];
    logic [7:0] io_m;
    bit         err_m;
    logic [9:0] pool [8];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_dut
        bus_slave_mem #(
            .ADDR_BITS   (10),
            .MEM_BASE    (16'h0000),
            .IO_PORT     (8'hF0),
            .WAIT_STATES (WS[g])
        ) dut (
            .clk         (clk),
            .rst         (rst),
            .haddress    (haddress),
            .ad_in       (ad_in),
            .ad_out      (ad_out_a[g]),
            .ad_oe       (ad_oe_a[g]),
            .ale         (ale),
            .iomn        (iomn),
            .rdn         (rdn),
            .wrn         (wrn),
            .ready       (ready_a[g]),
            .io_port_in  (io_port_in),
            .io_port_out (io_out_a[g]),
            .hit         (hit_a[g]),
            .bus_err     (err_a[g])
        );
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_cmp++;
        if (observed !== expected) begin
            n_bad++;
            $display("[TB] FAIL %s: observed %0h, expected %0h (t=%0t)", tag, observed, expected, $time);
        end
    endtask

    // kind: 0 read, 1 write, 2 read+write strobes together, 3 write aborted by a new ALE
    task automatic applyStimulus(input bit io, input logic [15:0] a, input int kind, input logic [7:0] data);
        bit         exp_hit;
        int         lows [N];
        bit         oe_seen [N];
        logic [9:0] idx;
        idx     = a[9:0];
        exp_hit = io ? (a[7:0] == 8'hF0) : (a[15:10] == 6'd0);

        @(negedge clk);
        ale = 1'b1; haddress = a[15:8]; ad_in = a[7:0]; iomn = io; rdn = 1'b1; wrn = 1'b1;
        @(negedge clk);
        for (int k = 0; k < N; k++) checkOutput($sformatf("hit ws%0d", WS[k]), 32'(hit_a[k]), 32'(exp_hit));
        ale   = 1'b0;
        ad_in = data;
        rdn   = !(kind == 0 || kind == 2);
        wrn   = !(kind == 1 || kind == 2 || kind == 3);
        for (int k = 0; k < N; k++) begin
            lows[k]    = 0;
            oe_seen[k] = 1'b0;
        end
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            for (int k = 0; k < N; k++) begin
                if (!ready_a[k]) lows[k]++;
                if (ad_oe_a[k]) oe_seen[k] = 1'b1;
            end
        end
        for (int k = 0; k < N; k++) begin
            if (kind == 0 && exp_hit) begin
                checkOutput($sformatf("ad_oe ws%0d", WS[k]), 32'(ad_oe_a[k]), 32'd1);
                if (io) checkOutput($sformatf("io_rd ws%0d", WS[k]), 32'(ad_out_a[k]), 32'(io_port_in));
                else if (mem_v[idx]) checkOutput($sformatf("mem_rd ws%0d", WS[k]), 32'(ad_out_a[k]), 32'(mem_m[idx]));
            end else begin
                checkOutput($sformatf("no_drive ws%0d", WS[k]), 32'(oe_seen[k]), 32'd0);
            end
            checkOutput($sformatf("ready_low ws%0d", WS[k]), 32'(lows[k]),
                        (exp_hit && kind != 2) ? 32'(WS[k]) : 32'd0);
        end

        if (kind == 3) begin
            ale = 1'b1; wrn = 1'b1; haddress = 8'h00; ad_in = 8'hF1; iomn = 1'b1;
            @(negedge clk);
            ale = 1'b0;
            for (int k = 0; k < N; k++) checkOutput($sformatf("abort_oe ws%0d", WS[k]), 32'(ad_oe_a[k]), 32'd0);
        end else begin
            rdn = 1'b1;
            wrn = 1'b1;
            if (kind == 1 && exp_hit) begin
                if (io) io_m = data;
                else begin
                    mem_m[idx] = data;
                    mem_v[idx] = 1'b1;
                end
            end
            if (kind == 2 && exp_hit) err_m = 1'b1;
            @(negedge clk);
            for (int k = 0; k < N; k++) begin
                checkOutput($sformatf("oe_after ws%0d", WS[k]), 32'(ad_oe_a[k]), 32'd0);
                checkOutput($sformatf("io_out ws%0d", WS[k]), 32'(io_out_a[k]), 32'(io_m));
                checkOutput($sformatf("bus_err ws%0d", WS[k]), 32'(err_a[k]), 32'(err_m));
            end
            @(negedge clk);
        end
    endtask

    initial begin
        int         r;
        logic [15:0] a;
        rst = 1'b1; ale = 1'b0; iomn = 1'b0; rdn = 1'b1; wrn = 1'b1;
        haddress = '0; ad_in = '0; io_port_in = '0;
        io_m = '0; err_m = 1'b0;
        for (int i = 0; i < 1024; i++) mem_v[i] = 1'b0;

        repeat (2) @(negedge clk);
        for (int k = 0; k < N; k++) begin
            checkOutput("rst_oe", 32'(ad_oe_a[k]), 32'd0);
            checkOutput("rst_ad_out", 32'(ad_out_a[k]), 32'd0);
            checkOutput("rst_ready", 32'(ready_a[k]), 32'd1);
            checkOutput("rst_io_out", 32'(io_out_a[k]), 32'd0);
            checkOutput("rst_hit", 32'(hit_a[k]), 32'd0);
            checkOutput("rst_err", 32'(err_a[k]), 32'd0);
        end
        rst = 1'b0;

        applyStimulus(1'b0, 16'h0012, 1, 8'hA5);
        applyStimulus(1'b0, 16'h0012, 0, 8'h00);
        applyStimulus(1'b1, 16'h00F0, 1, 8'h3C);
        io_port_in = 8'h81;
        applyStimulus(1'b1, 16'h00F0, 0, 8'h00);
        applyStimulus(1'b1, 16'h00F1, 0, 8'h00);
        applyStimulus(1'b0, 16'h8000, 0, 8'h00);
        applyStimulus(1'b0, 16'h0012, 2, 8'h77);
        applyStimulus(1'b0, 16'h0012, 0, 8'h00);
        applyStimulus(1'b0, 16'h0012, 3, 8'h99);
        applyStimulus(1'b0, 16'h0012, 0, 8'h00);

        for (int i = 0; i < 8; i++) begin
            pool[i] = 10'($urandom_range(0, 1023));
            applyStimulus(1'b0, {6'd0, pool[i]}, 1, 8'($urandom));
        end

        for (int t = 0; t < 40; t++) begin
            r = $urandom_range(0, 9);
            io_port_in = 8'($urandom);
            if (r < 6) applyStimulus(1'b0, {6'd0, pool[$urandom_range(0, 7)]}, $urandom_range(0, 1), 8'($urandom));
            else if (r == 6) begin
                a = 16'($urandom_range(16'h0400, 16'hFFFF));
                applyStimulus(1'b0, a, $urandom_range(0, 1), 8'($urandom));
            end
            else if (r == 7) applyStimulus(1'b1, 16'h00F0, $urandom_range(0, 1), 8'($urandom));
            else if (r == 8) applyStimulus(1'b1, {8'($urandom), 8'hF1}, $urandom_range(0, 1), 8'($urandom));
            else applyStimulus(1'b0, {6'd0, pool[$urandom_range(0, 7)]}, $urandom_range(2, 3), 8'($urandom));
        end

        @(negedge clk);
        ale = 1'b1; haddress = {6'd0, pool[0][9:8]}; ad_in = pool[0][7:0]; iomn = 1'b0;
        @(negedge clk);
        ale = 1'b0; rdn = 1'b0;
        repeat (6) @(negedge clk);
        for (int k = 0; k < N; k++) checkOutput("pre_rst_oe", 32'(ad_oe_a[k]), 32'd1);
        #2 rst = 1'b1;
        #1;
        for (int k = 0; k < N; k++) begin
            checkOutput("midrst_oe", 32'(ad_oe_a[k]), 32'd0);
            checkOutput("midrst_ready", 32'(ready_a[k]), 32'd1);
            checkOutput("midrst_io_out", 32'(io_out_a[k]), 32'd0);
            checkOutput("midrst_hit", 32'(hit_a[k]), 32'd0);
            checkOutput("midrst_err", 32'(err_a[k]), 32'd0);
        end
        rdn = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        io_m = '0;
        err_m = 1'b0;
        applyStimulus(1'b0, {6'd0, pool[0]}, 0, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
